// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic/arith ops, iterative MUL/DIVU/REMU
// Results are registered and framed by a start/busy/done handshake.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRLSIG    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CTRLSIG-1:0]    ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [CTRLSIG-1:0] OP_ADD  = 3'b000;
  localparam logic [CTRLSIG-1:0] OP_SUB  = 3'b001;
  localparam logic [CTRLSIG-1:0] OP_AND  = 3'b010;
  localparam logic [CTRLSIG-1:0] OP_OR   = 3'b011;
  localparam logic [CTRLSIG-1:0] OP_SLT  = 3'b100;
  localparam logic [CTRLSIG-1:0] OP_MUL  = 3'b101;
  localparam logic [CTRLSIG-1:0] OP_DIVU = 3'b110;
  localparam logic [CTRLSIG-1:0] OP_REMU = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_n;
  logic [CTRLSIG-1:0]      op_q;
  logic [CW-1:0]           cnt;
  logic                    eq_cap;
  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
  // mq:  multiplier (MUL) or dividend shifting out / quotient shifting in
  // mcand: multiplicand (shifted left each step) or divisor
  logic [DATA_WIDTH-1:0]   acc, mq, mcand;
  logic [DATA_WIDTH-1:0]   acc_n, mq_n, mcand_n;
  logic [DATA_WIDTH:0]     trial;
  logic [DATA_WIDTH-1:0]   quick;
  logic                    is_long;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = is_long ? RUN : DONE;
      RUN:     if (cnt == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    quick   = '0;
    is_long = 1'b0;
    case (ALUctrl)
      OP_ADD:  quick = ALUop1 + ALUop2;
      OP_SUB:  quick = ALUop1 - ALUop2;
      OP_AND:  quick = ALUop1 & ALUop2;
      OP_OR:   quick = ALUop1 | ALUop2;
      OP_SLT:  quick = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_MUL, OP_DIVU, OP_REMU: is_long = 1'b1;
      default: quick = '0;
    endcase
  end

  // One shift-add or restoring-division step; trial is one bit wider so the
  // shifted remainder cannot overflow before the compare.
  always_comb begin
    acc_n   = acc;
    mq_n    = mq;
    mcand_n = mcand;
    trial   = {acc, mq[DATA_WIDTH-1]} - {1'b0, mcand};
    if (op_q == OP_MUL) begin
      acc_n   = mq[0] ? (acc + mcand) : acc;
      mq_n    = mq >> 1;
      mcand_n = mcand << 1;
    end else begin
      acc_n = trial[DATA_WIDTH] ? {acc[DATA_WIDTH-2:0], mq[DATA_WIDTH-1]}
                                : trial[DATA_WIDTH-1:0];
      mq_n  = {mq[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      cnt    <= '0;
      eq_cap <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      mcand  <= '0;
      ALUout <= '0;
      EQ     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= ALUctrl;
            eq_cap <= (ALUop1 == ALUop2);
            if (is_long) begin
              cnt <= CW'(DATA_WIDTH);
              acc <= '0;
              if (ALUctrl == OP_MUL) begin
                mq    <= ALUop2;
                mcand <= ALUop1;
              end else begin
                mq    <= ALUop1;
                mcand <= ALUop2;
              end
            end else begin
              ALUout <= quick;
              EQ     <= (ALUop1 == ALUop2);
            end
          end
        end
        RUN: begin
          acc   <= acc_n;
          mq    <= mq_n;
          mcand <= mcand_n;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ALUout <= (op_q == OP_DIVU) ? mq_n : acc_n;
            EQ     <= eq_cap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed and randomized checks of alu_mc against an arithmetic model
module tb_alu_mc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ALUctrl;
  logic [W-1:0] ALUop1, ALUop2, ALUout;
  logic         EQ, busy, done;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.DATA_WIDTH(W), .CTRLSIG(3)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUctrl(ALUctrl),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUout(ALUout),
    .EQ(EQ), .busy(busy), .done(done)
  );

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd5: begin p = a * b; return p[W-1:0]; end
      3'd6: return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int           cyc;
    logic [W-1:0] prev;
    prev = ALUout;
    @(negedge clk);
    start = 1'b1; ALUctrl = op; ALUop1 = a; ALUop2 = b;
    @(negedge clk);
    start = 1'b0; ALUctrl = 3'($urandom); ALUop1 = W'($urandom); ALUop2 = W'($urandom);
    cyc = 1;
    if (op >= 3'd5) chk({tag, " hold"}, ALUout, prev);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " lat"}, cyc, (op >= 3'd5) ? 9 : 1);
    chk({tag, " out"}, ALUout, model(op, a, b));
    chk({tag, " eq"}, EQ, (a == b));
    chk({tag, " busy"}, busy, 1);
    @(negedge clk);
    chk({tag, " done1"}, done, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_done;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; ALUctrl = '0; ALUop1 = '0; ALUop2 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst out", ALUout, 0);
    chk("rst eq", EQ, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst = 1'b0;

    do_op(3'd0, 8'd200, 8'd100, "add wrap");
    do_op(3'd1, 8'd5, 8'd5, "sub eq");
    do_op(3'd4, 8'hFF, 8'h01, "slt neg");
    do_op(3'd5, 8'd13, 8'd11, "mul 13x11");
    do_op(3'd5, 8'd20, 8'd20, "mul trunc");
    do_op(3'd6, 8'd200, 8'd7, "divu");
    do_op(3'd7, 8'd200, 8'd7, "remu");
    do_op(3'd6, 8'h5A, 8'h00, "divu zero");
    do_op(3'd7, 8'h5A, 8'h00, "remu zero");
    do_op(3'd2, 8'hF0, 8'h3C, "and");
    do_op(3'd3, 8'hF0, 8'h3C, "or");

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom);
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      if ($urandom_range(0, 5) == 0) rb = ra;
      do_op(rop, ra, rb, "rand");
    end

    // start pulsed during RUN must be ignored
    @(negedge clk);
    start = 1'b1; ALUctrl = 3'd5; ALUop1 = 8'd3; ALUop2 = 8'd3;
    @(negedge clk);
    start = 1'b0; ALUop1 = 8'd77; ALUop2 = 8'd99;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) n_done++;
      if (i == 3) begin start = 1'b1; ALUctrl = 3'd0; ALUop1 = 8'd50; ALUop2 = 8'd60; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    chk("ign dones", n_done, 1);
    chk("ign out", ALUout, 9);
    chk("ign eq", EQ, 1);

    // reset in the middle of a multiply
    start = 1'b1; ALUctrl = 3'd5; ALUop1 = 8'd13; ALUop2 = 8'd11;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort out", ALUout, 0);
    chk("abort eq", EQ, 0);
    chk("abort busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort dones", n_done, 0);
    chk("abort hold", ALUout, 0);
    do_op(3'd0, 8'd1, 8'd2, "add after rst");

    // start held high: one op per two cycles
    @(negedge clk);
    start = 1'b1; ALUctrl = 3'd0; ALUop1 = 8'd1; ALUop2 = 8'd1;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    chk("stream dones", n_done, 2);
    chk("stream out", ALUout, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
